// File: rtl/comparator_seq_pkg.sv
// Shared types for comparator_seq: FSM state encoding and result codes
// consumed by the comparator and by anything that decodes its gt/lt/eq result.
package comparator_seq_pkg;

  typedef enum logic [0:0] {
    CMP_IDLE = 1'b0,
    CMP_RUN  = 1'b1
  } cmp_state_t;

  typedef logic [1:0] cmp_res_t;

  localparam cmp_res_t CMP_GT = 2'd1;
  localparam cmp_res_t CMP_LT = 2'd2;
  localparam cmp_res_t CMP_EQ = 2'd3;

endpackage

// File: rtl/comparator_digit.sv
// Combinational K-bit unsigned digit compare.
// Zero latency, no flow control.
module comparator_digit #(
  parameter int K = 2
) (
  input  logic [K-1:0] da,
  input  logic [K-1:0] db,
  output logic         dgt,
  output logic         dlt,
  output logic         deq
);

  assign dgt = (da > db);
  assign dlt = (da < db);
  assign deq = (da == db);

endmodule

// File: rtl/comparator_seq.sv
// Sequential MSB-first magnitude comparator, K bits per cycle with early exit; 1..N/K cycles.
// start is ignored while busy; COMPARATOR_SIGNED_EN adds the signed_mode port.
module comparator_seq
  import comparator_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
  input  logic         signed_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  localparam int D  = N / K;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  cmp_state_t      r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic            r_gt;
  logic            r_lt;
  logic            r_eq;

  logic [N-1:0]    w_flip;
  logic [K-1:0]    w_da;
  logic [K-1:0]    w_db;
  logic            w_dgt;
  logic            w_dlt;
  logic            w_deq;

  // Two's complement becomes offset binary by flipping the sign bit once at latch time.
`ifdef COMPARATOR_SIGNED_EN
  assign w_flip = {signed_mode, {(N-1){1'b0}}};
`else
  assign w_flip = '0;
`endif

  assign w_da = r_a[r_idx*K +: K];
  assign w_db = r_b[r_idx*K +: K];

  comparator_digit #(.K(K)) u_digit (
    .da  (w_da),
    .db  (w_db),
    .dgt (w_dgt),
    .dlt (w_dlt),
    .deq (w_deq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CMP_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CMP_IDLE: begin
          if (start) begin
            r_a     <= a ^ w_flip;
            r_b     <= b ^ w_flip;
            r_idx   <= IW'(D - 1);
            r_busy  <= 1'b1;
            r_state <= CMP_RUN;
          end
        end
        CMP_RUN: begin
          if (!w_deq) begin
            r_gt    <= w_dgt;
            r_lt    <= w_dlt;
            r_eq    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= CMP_IDLE;
          end else if (r_idx == '0) begin
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= CMP_IDLE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: begin
          r_state <= CMP_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign gt   = r_gt;
  assign lt   = r_lt;
  assign eq   = r_eq;

endmodule
